// File: rtl/fir_stereo_sched.sv
// fir_stereo_sched: shares one two-bank FIR core between the left and right
// channels. A stereo pair is issued left then right, both results are
// collected, and the pair is handed on as one strobe. A one-deep pending
// buffer absorbs a pair arriving while busy; a per-channel response timeout
// substitutes 0 for a missing result.
// Optional feature: define FIR_SCHED_BYPASS_EN to add the `bypass` input,
// which routes pairs arriving in IDLE straight to the outputs.

module fir_stereo_sched #(
  parameter int TIMEOUT = 255,
  parameter int DW      = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] l_din,
  input  logic [DW-1:0] r_din,
  input  logic          lr_valid,
  output logic [DW-1:0] fir_din,
  output logic          fir_din_valid,
  output logic          fir_ch,
  input  logic [DW-1:0] fir_dout,
  input  logic          fir_dout_valid,
  output logic [DW-1:0] l_dout,
  output logic [DW-1:0] r_dout,
  output logic          lr_dout_valid,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err,
  input  logic          clr_err
`ifdef FIR_SCHED_BYPASS_EN
  ,
  input  logic          bypass
`endif
);

  // state   | meaning
  // IDLE    | no pair in flight, waiting for lr_valid
  // ISSUE_L | left sample on fir_din, issue strobe high, bank 0
  // WAIT_L  | waiting for the left result or the timeout
  // ISSUE_R | right sample on fir_din, issue strobe high, bank 1
  // WAIT_R  | waiting for the right result or the timeout
  // OUT     | both results captured; strobe the pair on the next cycle

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_L = 3'd1,
    WAIT_L  = 3'd2,
    ISSUE_R = 3'd3,
    WAIT_R  = 3'd4,
    OUT     = 3'd5
  } state_t;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] pair_r;
  logic          pend_vld;
  logic [DW-1:0] pend_l;
  logic [DW-1:0] pend_r;
  logic          in_flight;

  // busy is a decode of the state register, so it changes on clock edges only
  assign busy = (state != IDLE);

  // ISSUE/WAIT states are the window in which a new pair goes to the pending buffer
  assign in_flight = (state == ISSUE_L) || (state == WAIT_L) ||
                     (state == ISSUE_R) || (state == WAIT_R);

  // Sequencer: state, issue strobes, result capture, pending buffer and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pair_r        <= '0;
      pend_vld      <= 1'b0;
      pend_l        <= '0;
      pend_r        <= '0;
      fir_din       <= '0;
      fir_din_valid <= 1'b0;
      fir_ch        <= 1'b0;
      l_dout        <= '0;
      r_dout        <= '0;
      lr_dout_valid <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      fir_din_valid <= 1'b0;
      lr_dout_valid <= 1'b0;

      // clear first so that a set later in this block wins
      if (clr_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          fir_ch <= 1'b0;
          if (lr_valid) begin
`ifdef FIR_SCHED_BYPASS_EN
            if (bypass) begin
              l_dout        <= l_din;
              r_dout        <= r_din;
              lr_dout_valid <= 1'b1;
            end else begin
`endif
              pair_r        <= r_din;
              fir_din       <= l_din;
              fir_din_valid <= 1'b1;
              state         <= ISSUE_L;
`ifdef FIR_SCHED_BYPASS_EN
            end
`endif
          end
        end

        ISSUE_L: begin
          cnt   <= '0;
          state <= WAIT_L;
        end

        WAIT_L: begin
          if (fir_dout_valid || (cnt == CW'(TIMEOUT))) begin
            if (fir_dout_valid) begin
              l_dout <= fir_dout;
            end else begin
              l_dout      <= '0;
              timeout_err <= 1'b1;
            end
            fir_din       <= pair_r;
            fir_din_valid <= 1'b1;
            fir_ch        <= 1'b1;
            state         <= ISSUE_R;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ISSUE_R: begin
          cnt   <= '0;
          state <= WAIT_R;
        end

        WAIT_R: begin
          if (fir_dout_valid) begin
            r_dout <= fir_dout;
            state  <= OUT;
          end else if (cnt == CW'(TIMEOUT)) begin
            r_dout      <= '0;
            timeout_err <= 1'b1;
            state       <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        OUT: begin
          lr_dout_valid <= 1'b1;
          if (pend_vld) begin
            // pending pair starts now; a pair arriving this cycle takes its slot
            pair_r        <= pend_r;
            fir_din       <= pend_l;
            fir_din_valid <= 1'b1;
            fir_ch        <= 1'b0;
            state         <= ISSUE_L;
            pend_vld      <= lr_valid;
            if (lr_valid) begin
              pend_l <= l_din;
              pend_r <= r_din;
            end
          end else if (lr_valid) begin
            // nothing pending: the arriving pair is started directly
            pair_r        <= r_din;
            fir_din       <= l_din;
            fir_din_valid <= 1'b1;
            fir_ch        <= 1'b0;
            state         <= ISSUE_L;
          end else begin
            fir_ch <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          fir_ch <= 1'b0;
          state  <= IDLE;
        end
      endcase

      if (in_flight && lr_valid) begin
        if (!pend_vld) begin
          pend_vld <= 1'b1;
          pend_l   <= l_din;
          pend_r   <= r_din;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fir_stereo_sched.md
Name: fir_stereo_sched

Overview:
- Time-multiplexes one two-bank FIR core between the left and right audio channels of the PmodI2S2 path.
- Takes a stereo sample pair from the I2S receiver and issues left, then right, to the FIR. `fir_ch` selects the core's delay-line bank.
- Collects both filtered results and presents them as one stereo pair to the I2S transmitter.
- Provides a one-deep pending buffer, a per-channel response timeout, and sticky error flags.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for `fir_dout_valid` after an issue, before substituting 0.
- DW, 24: sample width in bits (two's complement).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- l_din  in  DW  left input sample.
- r_din  in  DW  right input sample.
- lr_valid  in  1  one-cycle pulse: l_din/r_din hold a valid pair.
- fir_din  out  DW  sample sent to the FIR core.
- fir_din_valid  out  1  one-cycle issue strobe to the FIR core.
- fir_ch  out  1  FIR bank select: 0 = left, 1 = right.
- fir_dout  in  DW  FIR result.
- fir_dout_valid  in  1  one-cycle FIR result strobe.
- l_dout  out  DW  filtered left sample.
- r_dout  out  DW  filtered right sample.
- lr_dout_valid  out  1  one-cycle pulse: l_dout/r_dout hold a valid pair.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: an input pair was dropped.
- timeout_err  out  1  sticky: a FIR response timed out.
- clr_err  in  1  synchronous clear of overrun and timeout_err.

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs are 0, state is IDLE, pending buffer is empty, timeout counter is 0. Reset mid-sequence abandons the in-flight pair without emitting it.
- FSM states: IDLE, ISSUE_L, WAIT_L, ISSUE_R, WAIT_R, OUT.
- IDLE: on lr_valid, latch the pair and go to ISSUE_L.
- ISSUE_L: drive fir_din_valid=1, fir_ch=0, fir_din=latched L for exactly one cycle; clear the counter; go to WAIT_L.
- WAIT_L: on fir_dout_valid, capture fir_dout into l_dout and go to ISSUE_R.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT, set l_dout=0, set timeout_err, go to ISSUE_R.
- ISSUE_R / WAIT_R: same as ISSUE_L / WAIT_L with fir_ch=1 and r_dout.
- OUT: lr_dout_valid=1 for one cycle. If the pending buffer is valid, move it into the latch and go to ISSUE_L; else go to IDLE.
- Latency: lr_valid at cycle 0 gives fir_din_valid at cycle 1. With FIR latency N, lr_dout_valid occurs at cycle 2N+4.
- fir_ch is held stable from ISSUE through WAIT of its channel. It is 0 in IDLE.
- fir_dout_valid outside WAIT_L/WAIT_R is ignored, with no flag.
- lr_valid while busy:
  - pending empty: store the pair in pending.
  - pending full: drop the pair and set overrun.
  - In OUT, when pending is being consumed the same cycle, the new pair replaces pending with no overrun.
- l_dout/r_dout hold their values until the next OUT.
- clr_err clears both flags. If a set event occurs in the same cycle, set wins.
- No arithmetic is performed: samples pass through bit-exact.

Optional Feature:
- Macro: FIR_SCHED_BYPASS_EN.
- When defined:
  - Adds input `bypass` (1 bit).
  - With bypass=1 in IDLE, lr_valid copies l_din/r_din to l_dout/r_dout and pulses lr_dout_valid on the next cycle.
  - In that bypass path, fir_din_valid is never asserted and busy stays 0.
  - bypass is sampled only in IDLE; a change mid-sequence takes effect after OUT.
- When undefined: no bypass port; all pairs go through the FIR.

Test Plan:
- FIR model latency 40, dout=din/2. Pulse lr_valid with L='h400000, R='hC00000 -> fir_din_valid at cycle 1 (ch0, 'h400000) and cycle 42 (ch1, 'hC00000); lr_dout_valid at cycle 84 with l_dout='h200000, r_dout='hE00000.
- Second lr_valid 10 cycles after the first -> stored in pending; its ISSUE_L immediately follows OUT; overrun stays 0.
- Three lr_valid pulses within one busy window -> the third pair is dropped and overrun=1. After clr_err, overrun=0.
- FIR model never responds on ch1, TIMEOUT=255 -> r_dout=0 and timeout_err=1; lr_dout_valid fires at the timeout boundary; the next pair is processed normally.
- rst low for 3 cycles during WAIT_R -> all outputs 0 immediately; no lr_dout_valid; the next lr_valid restarts at ISSUE_L with fir_ch=0.
- FIR_SCHED_BYPASS_EN defined, bypass=1, L='h123456, R='h654321 -> next-cycle lr_dout_valid with identical values; fir_din_valid stays 0.
